// File: rtl/exec_unit_param_pkg.sv
// Shared definitions for the parameterised execution unit: instruction fields,
// opcodes, controller states and flag bit positions.
package exec_unit_param_pkg;

  localparam int IR_W     = 32;
  localparam int OPC_HI   = 31;
  localparam int OPC_LO   = 27;
  localparam int RDST_HI  = 26;
  localparam int RDST_LO  = 22;
  localparam int RSRC1_HI = 21;
  localparam int RSRC1_LO = 17;
  localparam int IMM_BIT  = 16;
  localparam int RSRC2_HI = 15;
  localparam int RSRC2_LO = 11;
  localparam int ISRC_HI  = 15;
  localparam int ISRC_LO  = 0;

  localparam logic [4:0] OP_MOVSGPR = 5'b00000;
  localparam logic [4:0] OP_MOV     = 5'b00001;
  localparam logic [4:0] OP_ADD     = 5'b00010;
  localparam logic [4:0] OP_SUB     = 5'b00011;
  localparam logic [4:0] OP_MUL     = 5'b00100;

  typedef enum logic {ST_IDLE, ST_MUL} state_e;

  localparam int FLAG_S = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  function automatic logic [3:0] pack_flags(input logic s, input logic z,
                                            input logic c, input logic v);
    logic [3:0] f;
    f         = '0;
    f[FLAG_S] = s;
    f[FLAG_Z] = z;
    f[FLAG_C] = c;
    f[FLAG_V] = v;
    return f;
  endfunction

endpackage

// File: rtl/exec_unit_param_seq_mul.sv
// Unsigned shift-add multiplier retiring one multiplier bit per clock.
// done and product are combinational during the final step so the owner can
// latch the result on the same edge that completes the last partial sum.
module seq_mul #(
  parameter int DATA_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_W-1:0]     op_a,
  input  logic [DATA_W-1:0]     op_b,
  output logic                  busy,
  output logic                  done,
  output logic [2*DATA_W-1:0]   product
);

  localparam int CW = $clog2(DATA_W) + 1;
  localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

  logic [2*DATA_W-1:0] acc;
  logic [2*DATA_W-1:0] mcand;
  logic [DATA_W-1:0]   mplier;
  logic [CW-1:0]       cnt;

  assign product = mplier[0] ? (acc + mcand) : acc;
  assign done    = busy && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
    end else if (start && !busy) begin
      acc    <= '0;
      mcand  <= (2*DATA_W)'(op_a);
      mplier <= op_b;
      cnt    <= '0;
      busy   <= 1'b1;
    end else if (busy) begin
      acc    <= product;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/exec_unit_param.sv
// Single-issue execution unit: register file, add/sub/mov in one cycle and a
// multi-cycle unsigned multiply whose upper half lands in sgpr.
module exec_unit_param
  import exec_unit_param_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int NUM_GPR = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ir_valid,
  input  logic [IR_W-1:0]   ir,
  output logic              ir_ready,
  output logic              done,
  output logic              illegal,
  input  logic [4:0]        dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic [DATA_W-1:0] sgpr,
  output logic [3:0]        flags
);

  localparam int AW = $clog2(NUM_GPR);
  localparam logic [5:0] GPR_LIMIT = 6'(NUM_GPR);

  logic [DATA_W-1:0] gpr [NUM_GPR];
  state_e            state;
  logic [4:0]        mul_rdst;

  logic [4:0]  opcode, rdst, rsrc1, rsrc2;
  logic        imm_mod, accept;
  logic [15:0] isrc;

  function automatic logic addr_ok(input logic [4:0] a);
    return {1'b0, a} < GPR_LIMIT;
  endfunction

  assign opcode  = ir[OPC_HI:OPC_LO];
  assign rdst    = ir[RDST_HI:RDST_LO];
  assign rsrc1   = ir[RSRC1_HI:RSRC1_LO];
  assign imm_mod = ir[IMM_BIT];
  assign rsrc2   = ir[RSRC2_HI:RSRC2_LO];
  assign isrc    = ir[ISRC_HI:ISRC_LO];

  logic mul_busy, mul_done;
  logic [2*DATA_W-1:0] mul_product;

  assign ir_ready = (state == ST_IDLE) && !mul_busy && !rst;
  assign accept   = ir_valid && ir_ready;

  // Out-of-range register addresses behave as a hardwired zero source.
  logic [DATA_W-1:0] op_a, reg_b, op_b;
  always_comb begin
    op_a     = '0;
    reg_b    = '0;
    dbg_data = '0;
    if (addr_ok(rsrc1))    op_a     = gpr[rsrc1[AW-1:0]];
    if (addr_ok(rsrc2))    reg_b    = gpr[rsrc2[AW-1:0]];
    if (addr_ok(dbg_addr)) dbg_data = gpr[dbg_addr[AW-1:0]];
  end

  assign op_b = imm_mod ? DATA_W'(isrc) : reg_b;

  logic [DATA_W:0] add_full, sub_full;
  logic            add_v, sub_v;
  assign add_full = {1'b0, op_a} + {1'b0, op_b};
  assign sub_full = {1'b0, op_a} - {1'b0, op_b};
  assign add_v = (op_a[DATA_W-1] == op_b[DATA_W-1]) &&
                 (add_full[DATA_W-1] != op_a[DATA_W-1]);
  assign sub_v = (op_a[DATA_W-1] != op_b[DATA_W-1]) &&
                 (sub_full[DATA_W-1] != op_a[DATA_W-1]);

  seq_mul #(.DATA_W(DATA_W)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (accept && (opcode == OP_MUL)),
    .op_a    (op_a),
    .op_b    (op_b),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );

  // One shared write port: either the accepted single-cycle op or the multiply result.
  logic              wr_en;
  logic [4:0]        wr_addr;
  logic [DATA_W-1:0] wr_data;
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = rdst;
    wr_data = op_b;
    if (state == ST_MUL) begin
      wr_en   = mul_done;
      wr_addr = mul_rdst;
      wr_data = mul_product[DATA_W-1:0];
    end else if (accept) begin
      case (opcode)
        OP_MOVSGPR: begin wr_en = 1'b1; wr_data = sgpr; end
        OP_MOV:     begin wr_en = 1'b1; wr_data = imm_mod ? op_b : op_a; end
        OP_ADD:     begin wr_en = 1'b1; wr_data = add_full[DATA_W-1:0]; end
        OP_SUB:     begin wr_en = 1'b1; wr_data = sub_full[DATA_W-1:0]; end
        default:    wr_en = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_GPR; i++) gpr[i] <= '0;
      sgpr     <= '0;
      flags    <= '0;
      state    <= ST_IDLE;
      done     <= 1'b0;
      illegal  <= 1'b0;
      mul_rdst <= '0;
    end else begin
      done    <= 1'b0;
      illegal <= 1'b0;
      if (wr_en && addr_ok(wr_addr)) gpr[wr_addr[AW-1:0]] <= wr_data;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            case (opcode)
              OP_MOVSGPR, OP_MOV: done <= 1'b1;
              OP_ADD: begin
                done  <= 1'b1;
                flags <= pack_flags(add_full[DATA_W-1], add_full[DATA_W-1:0] == '0,
                                    add_full[DATA_W], add_v);
              end
              OP_SUB: begin
                done  <= 1'b1;
                flags <= pack_flags(sub_full[DATA_W-1], sub_full[DATA_W-1:0] == '0,
                                    sub_full[DATA_W], sub_v);
              end
              OP_MUL: begin
                mul_rdst <= rdst;
                state    <= ST_MUL;
              end
              default: begin
                done    <= 1'b1;
                illegal <= 1'b1;
              end
            endcase
          end
        end
        ST_MUL: begin
          if (mul_done) begin
            sgpr  <= mul_product[2*DATA_W-1:DATA_W];
            flags <= pack_flags(mul_product[2*DATA_W-1], mul_product == '0,
                                mul_product[2*DATA_W-1:DATA_W] != '0, 1'b0);
            done  <= 1'b1;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_exec_unit_param.sv
// Self-checking bench for exec_unit_param: a 16-bit/32-register unit and a
// 32-bit/8-register unit, with retirement timing tracked through a scoreboard.
module tb_exec_unit_param;

  localparam logic [4:0] OP_MOVSGPR = 5'b00000;
  localparam logic [4:0] OP_MOV     = 5'b00001;
  localparam logic [4:0] OP_ADD     = 5'b00010;
  localparam logic [4:0] OP_SUB     = 5'b00011;
  localparam logic [4:0] OP_MUL     = 5'b00100;
  localparam logic [4:0] OP_BAD     = 5'b11111;
  localparam logic [31:0] IR_IDLE   = 32'hFFFF_FFFF;

  logic clk;
  logic rst;
  logic        valid16, ready16, done16, illegal16;
  logic [31:0] ir16;
  logic [4:0]  dbg16;
  logic [15:0] data16, sgpr16;
  logic [3:0]  flags16;
  logic        valid32, ready32, done32, illegal32;
  logic [31:0] ir32;
  logic [4:0]  dbg32;
  logic [31:0] data32, sgpr32;
  logic [3:0]  flags32;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    int    unit;
    bit    illegal;
    int    cyc;
    string tag;
  } exp_t;
  exp_t sb[$];

  exec_unit_param dut16 (
    .clk(clk), .rst(rst), .ir_valid(valid16), .ir(ir16), .ir_ready(ready16),
    .done(done16), .illegal(illegal16), .dbg_addr(dbg16), .dbg_data(data16),
    .sgpr(sgpr16), .flags(flags16)
  );

  exec_unit_param #(.DATA_W(32), .NUM_GPR(8)) dut32 (
    .clk(clk), .rst(rst), .ir_valid(valid32), .ir(ir32), .ir_ready(ready32),
    .done(done32), .illegal(illegal32), .dbg_addr(dbg32), .dbg_data(data32),
    .sgpr(sgpr32), .flags(flags32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] encR(input logic [4:0] op, input logic [4:0] rd,
                                       input logic [4:0] rs1, input logic [4:0] rs2);
    return {op, rd, rs1, 1'b0, rs2, 11'd0};
  endfunction

  function automatic logic [31:0] encI(input logic [4:0] op, input logic [4:0] rd,
                                       input logic [4:0] rs1, input logic [15:0] imm);
    return {op, rd, rs1, 1'b1, imm};
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, actual, expected);
    end
  endtask

  // Called on every retirement pulse; compares against the oldest pending issue.
  task automatic onRetire(input int unit, input logic d, input logic il);
    exp_t e;
    checkOutput($sformatf("u%0d_retire_expected", unit), 64'(sb.size() != 0), 64'(1));
    if (sb.size() == 0) return;
    e = sb.pop_front();
    checkOutput({e.tag, "_unit"},    64'(unit), 64'(e.unit));
    checkOutput({e.tag, "_done"},    64'(d),    64'(1));
    checkOutput({e.tag, "_illegal"}, 64'(il),   64'(e.illegal));
    checkOutput({e.tag, "_cycle"},   64'(cyc),  64'(e.cyc));
  endtask

  always @(negedge clk) begin
    if (done16 === 1'b1 || illegal16 === 1'b1) onRetire(0, done16, illegal16);
    if (done32 === 1'b1 || illegal32 === 1'b1) onRetire(1, done32, illegal32);
  end

  // Entered and left on a falling edge; the instruction is offered for one rising edge.
  task automatic applyStimulus(input int unit, input logic [31:0] instr, input bit expIll,
                               input int lat, input bit expectDone, input string tag);
    exp_t e;
    if (unit == 0) begin ir16 = instr; valid16 = 1'b1; end
    else           begin ir32 = instr; valid32 = 1'b1; end
    if (expectDone) begin
      e.unit = unit; e.illegal = expIll; e.cyc = cyc + lat; e.tag = tag;
      sb.push_back(e);
    end
    @(posedge clk);
    @(negedge clk);
    valid16 = 1'b0; ir16 = IR_IDLE;
    valid32 = 1'b0; ir32 = IR_IDLE;
  endtask

  task automatic readCheck(input int unit, input logic [4:0] addr,
                           input logic [31:0] expected, input string tag);
    if (unit == 0) dbg16 = addr; else dbg32 = addr;
    #1;
    if (unit == 0) checkOutput(tag, 64'(data16), 64'(expected));
    else           checkOutput(tag, 64'(data32), 64'(expected));
    @(negedge clk);
  endtask

  task automatic drain(input int budget, input string tag);
    for (int i = 0; i < budget && sb.size() != 0; i++) @(negedge clk);
    checkOutput(tag, 64'(sb.size()), 64'(0));
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish, got cycle %0d, want end", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lowCnt;
    rst = 1'b1;
    valid16 = 1'b0; ir16 = IR_IDLE; dbg16 = '0;
    valid32 = 1'b0; ir32 = IR_IDLE; dbg32 = '0;
    repeat (3) @(negedge clk);

    checkOutput("rst_ready16",   64'(ready16),   64'(0));
    checkOutput("rst_done16",    64'(done16),    64'(0));
    checkOutput("rst_illegal16", 64'(illegal16), 64'(0));
    checkOutput("rst_sgpr16",    64'(sgpr16),    64'(0));
    checkOutput("rst_flags16",   64'(flags16),   64'(0));
    checkOutput("rst_ready32",   64'(ready32),   64'(0));
    readCheck(0, 5'd3, 32'h0, "rst_r3");

    // Release and issue on the very first edge; three back-to-back retirements.
    rst = 1'b0;
    applyStimulus(0, encI(OP_MOV, 5'd1, 5'd0, 16'h0005), 0, 1, 1, "mov_r1");
    applyStimulus(0, encI(OP_MOV, 5'd2, 5'd0, 16'h0003), 0, 1, 1, "mov_r2");
    applyStimulus(0, encR(OP_ADD, 5'd3, 5'd1, 5'd2),     0, 1, 1, "add_r3");
    checkOutput("add_r3_flags", 64'(flags16), 64'(4'b0000));
    readCheck(0, 5'd3, 32'h0008, "add_r3_val");

    applyStimulus(0, encI(OP_MOV, 5'd1, 5'd0, 16'hFFFF), 0, 1, 1, "mov_ffff");
    applyStimulus(0, encI(OP_ADD, 5'd4, 5'd1, 16'h0001), 0, 1, 1, "add_wrap");
    checkOutput("add_wrap_flags", 64'(flags16), 64'(4'b0110));
    readCheck(0, 5'd4, 32'h0000, "add_wrap_val");
    applyStimulus(0, encI(OP_SUB, 5'd5, 5'd4, 16'h0001), 0, 1, 1, "sub_borrow");
    checkOutput("sub_borrow_flags", 64'(flags16), 64'(4'b1010));
    readCheck(0, 5'd5, 32'hFFFF, "sub_borrow_val");

    applyStimulus(0, encI(OP_MOV, 5'd8, 5'd0, 16'h7FFF), 0, 1, 1, "mov_7fff");
    applyStimulus(0, encI(OP_ADD, 5'd9, 5'd8, 16'h0001), 0, 1, 1, "add_ovf");
    checkOutput("add_ovf_flags", 64'(flags16), 64'(4'b1001));
    readCheck(0, 5'd9, 32'h8000, "add_ovf_val");
    applyStimulus(0, encR(OP_SUB, 5'd10, 5'd9, 5'd2), 0, 1, 1, "sub_ovf");
    checkOutput("sub_ovf_flags", 64'(flags16), 64'(4'b0001));
    readCheck(0, 5'd10, 32'h7FFD, "sub_ovf_val");

    applyStimulus(0, encI(OP_MOV, 5'd11, 5'd0, 16'h0010), 0, 1, 1, "mov_r11");
    applyStimulus(0, encI(OP_ADD, 5'd12, 5'd11, 16'h0001), 0, 1, 1, "dep_add");
    readCheck(0, 5'd12, 32'h0011, "dep_add_val");

    // Multiply; an instruction is offered throughout the busy window and must be ignored.
    applyStimulus(0, encI(OP_MOV, 5'd1, 5'd0, 16'h1234), 0, 1, 1, "mov_1234");
    applyStimulus(0, encI(OP_MUL, 5'd6, 5'd1, 16'h0100), 0, 17, 1, "mul16");
    lowCnt = 0;
    for (int i = 0; i < 16; i++) begin
      if (ready16 == 1'b0) lowCnt++;
      ir16    = encI(OP_MOV, 5'd13, 5'd0, 16'h0099);
      valid16 = (i < 15);
      @(negedge clk);
    end
    valid16 = 1'b0; ir16 = IR_IDLE;
    checkOutput("mul16_busy_cycles", 64'(lowCnt), 64'(16));
    checkOutput("mul16_ready_back", 64'(ready16), 64'(1));
    drain(5, "mul16_retired");
    checkOutput("mul16_sgpr",  64'(sgpr16),  64'(16'h0012));
    checkOutput("mul16_flags", 64'(flags16), 64'(4'b0010));
    readCheck(0, 5'd6,  32'h3400, "mul16_low");
    readCheck(0, 5'd13, 32'h0000, "busy_offer_ignored");

    applyStimulus(0, encR(OP_MOVSGPR, 5'd7, 5'd0, 5'd0), 0, 1, 1, "movsgpr");
    readCheck(0, 5'd7, 32'h0012, "movsgpr_val");
    checkOutput("movsgpr_flags", 64'(flags16), 64'(4'b0010));

    applyStimulus(0, encR(OP_BAD, 5'd1, 5'd2, 5'd3), 1, 1, 1, "illegal_1f");
    applyStimulus(0, encI(5'b00101, 5'd1, 5'd1, 16'hAAAA), 1, 1, 1, "illegal_05");
    checkOutput("illegal_flags", 64'(flags16), 64'(4'b0010));
    checkOutput("illegal_sgpr",  64'(sgpr16),  64'(16'h0012));
    readCheck(0, 5'd1, 32'h1234, "illegal_r1");
    readCheck(0, 5'd7, 32'h0012, "illegal_r7");

    applyStimulus(0, encR(OP_ADD, 5'd1, 5'd1, 5'd1), 0, 1, 1, "add_self");
    readCheck(0, 5'd1, 32'h2468, "add_self_val");

    // Reset five cycles into a multiply, then issue on the first edge after release.
    applyStimulus(0, encI(OP_MUL, 5'd6, 5'd1, 16'h0003), 0, 0, 0, "mul_abort");
    repeat (4) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("abort_ready_in_rst", 64'(ready16), 64'(0));
    rst = 1'b0;
    applyStimulus(0, encI(OP_MOV, 5'd2, 5'd0, 16'h00AA), 0, 1, 1, "post_rst_mov");
    repeat (20) @(negedge clk);
    checkOutput("abort_ready_after", 64'(ready16), 64'(1));
    checkOutput("abort_sgpr", 64'(sgpr16), 64'(0));
    readCheck(0, 5'd6, 32'h0, "abort_r6");
    readCheck(0, 5'd1, 32'h0, "abort_r1_cleared");
    readCheck(0, 5'd2, 32'h00AA, "post_rst_r2");

    // Wide unit with a reduced register file.
    applyStimulus(1, encI(OP_MOV, 5'd9, 5'd0, 16'h0055), 0, 1, 1, "u32_mov_r9");
    readCheck(1, 5'd9, 32'h0, "u32_r9_discard");
    applyStimulus(1, encI(OP_MOV, 5'd7, 5'd0, 16'h0077), 0, 1, 1, "u32_mov_r7");
    readCheck(1, 5'd7, 32'h0000_0077, "u32_r7");
    applyStimulus(1, encI(OP_SUB, 5'd1, 5'd0, 16'h0001), 0, 1, 1, "u32_sub");
    checkOutput("u32_sub_flags", 64'(flags32), 64'(4'b1010));
    readCheck(1, 5'd1, 32'hFFFF_FFFF, "u32_sub_val");
    applyStimulus(1, encI(OP_MUL, 5'd2, 5'd1, 16'h0002), 0, 33, 1, "u32_mul");
    drain(40, "u32_mul_retired");
    checkOutput("u32_mul_sgpr",  64'(sgpr32),  64'(32'h0000_0001));
    checkOutput("u32_mul_flags", 64'(flags32), 64'(4'b0010));
    readCheck(1, 5'd2, 32'hFFFF_FFFE, "u32_mul_low");
    applyStimulus(1, encR(OP_MUL, 5'd3, 5'd7, 5'd7), 0, 33, 1, "u32_mul_reg");
    drain(40, "u32_mul_reg_retired");
    readCheck(1, 5'd3, 32'h0000_3751, "u32_mul_reg_low");
    checkOutput("u32_mul_reg_flags", 64'(flags32), 64'(4'b0000));
    applyStimulus(1, encR(OP_MUL, 5'd4, 5'd1, 5'd0), 0, 33, 1, "u32_mul_zero");
    drain(40, "u32_mul_zero_retired");
    checkOutput("u32_mul_zero_flags", 64'(flags32), 64'(4'b0100));
    checkOutput("u32_mul_zero_sgpr",  64'(sgpr32),  64'(0));

    drain(100, "scoreboard_drained");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
